// File: rtl/player_collision_tracker.sv
// Player collision tracker: detects overlap between a drawn obstacle pixel
// and the player box, manages health and a post-hit invulnerability window
// with a blinking player, and flags game over when health runs out.
module player_collision_tracker #(
  parameter int PLAYER_W      = 20,
  parameter int PLAYER_H      = 20,
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_CYCLES = 65000000,
  parameter int FLASH_CYCLES  = 3250000,
  parameter int CNT_W         = 26
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic        new_game,
  input  logic        obstacle_working,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  output logic        hit,
  output logic [2:0]  health,
  output logic        invulnerable,
  output logic        player_visible,
  output logic        game_over
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_INVULN, S_DEAD} state_t;

  localparam logic [CNT_W-1:0] INV_LAST    = CNT_W'(INVULN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [2:0]       HEALTH_INIT = 3'(MAX_HEALTH);
  localparam logic [12:0]      PW_M1       = 13'(PLAYER_W - 1);
  localparam logic [12:0]      PH_M1       = 13'(PLAYER_H - 1);

  state_t           state_q, state_d;
  logic             hit_q, hit_d;
  logic [2:0]       health_q, health_d;
  logic             inv_q, inv_d;
  logic             vis_q, vis_d;
  logic             over_q, over_d;
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  // Box extents are formed at 13 bits so a box near 4095 does not wrap.
  logic [12:0] x_hi, y_hi;
  logic        pix_valid, overlap, collide;

  assign x_hi      = {1'b0, player_x} + PW_M1;
  assign y_hi      = {1'b0, player_y} + PH_M1;
  assign pix_valid = ((obstacle_x != 12'd0) || (obstacle_y != 12'd0)) && obstacle_working;
  assign overlap   = (obstacle_x >= player_x) && ({1'b0, obstacle_x} <= x_hi) &&
                     (obstacle_y >= player_y) && ({1'b0, obstacle_y} <= y_hi);
  assign collide   = pix_valid && overlap;

  // Next-state and next-output logic; new_game overrides everything.
  always_comb begin
    state_d     = state_q;
    hit_d       = 1'b0;
    health_d    = health_q;
    inv_d       = inv_q;
    vis_d       = vis_q;
    over_d      = over_q;
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    if (new_game) begin
      health_d    = HEALTH_INIT;
      over_d      = 1'b0;
      inv_d       = 1'b0;
      vis_d       = 1'b1;
      inv_cnt_d   = '0;
      blink_cnt_d = '0;
      state_d     = game_on ? S_ARMED : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          inv_d       = 1'b0;
          vis_d       = 1'b1;
          inv_cnt_d   = '0;
          blink_cnt_d = '0;
          if (game_on) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (!game_on) begin
            state_d = S_IDLE;
          end else if (collide && (health_q != 3'd0)) begin
            hit_d    = 1'b1;
            health_d = health_q - 3'd1;
            if (health_q == 3'd1) begin
              state_d = S_DEAD;
              over_d  = 1'b1;
            end else begin
              state_d     = S_INVULN;
              inv_d       = 1'b1;
              vis_d       = 1'b1;
              inv_cnt_d   = '0;
              blink_cnt_d = '0;
            end
          end
        end
        S_INVULN: begin
          if (!game_on || (inv_cnt_q == INV_LAST)) begin
            // Leaving the window either way: solid player, counters idle.
            state_d     = game_on ? S_ARMED : S_IDLE;
            inv_d       = 1'b0;
            vis_d       = 1'b1;
            inv_cnt_d   = '0;
            blink_cnt_d = '0;
          end else begin
            inv_cnt_d = inv_cnt_q + 1'b1;
            if (blink_cnt_q == FLASH_LAST) begin
              blink_cnt_d = '0;
              vis_d       = ~vis_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
        S_DEAD: begin
          over_d   = 1'b1;
          vis_d    = 1'b1;
          health_d = 3'd0;
          inv_d    = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hit_q       <= 1'b0;
      health_q    <= HEALTH_INIT;
      inv_q       <= 1'b0;
      vis_q       <= 1'b1;
      over_q      <= 1'b0;
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      health_q    <= health_d;
      inv_q       <= inv_d;
      vis_q       <= vis_d;
      over_q      <= over_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign hit            = hit_q;
  assign health         = health_q;
  assign invulnerable   = inv_q;
  assign player_visible = vis_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_player_collision_tracker.sv
// Testbench for player_collision_tracker: directed sequences, a vector
// table, and randomized traffic checked against a behavioural model.
module tb_player_collision_tracker;

  localparam int PW    = 20;
  localparam int PH    = 20;
  localparam int MAXH  = 3;
  localparam int INV   = 20;
  localparam int FLASH = 4;

  logic        pclk;
  logic        rst, game_on, new_game, obstacle_working;
  logic [11:0] obstacle_x, obstacle_y, player_x, player_y;
  logic        hit, invulnerable, player_visible, game_over;
  logic [2:0]  health;

  int errors = 0;
  int checks = 0;

  // Behavioural model: health, dead flag, playing flag and cycles of
  // invulnerability remaining. Visibility is derived from elapsed time.
  int m_hit, m_health, m_dead, m_playing, m_inv_left;

  player_collision_tracker #(
    .PLAYER_W(PW), .PLAYER_H(PH), .MAX_HEALTH(MAXH),
    .INVULN_CYCLES(INV), .FLASH_CYCLES(FLASH), .CNT_W(26)
  ) dut (
    .pclk(pclk), .rst(rst), .game_on(game_on), .new_game(new_game),
    .obstacle_working(obstacle_working),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .player_x(player_x), .player_y(player_y),
    .hit(hit), .health(health), .invulnerable(invulnerable),
    .player_visible(player_visible), .game_over(game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic int m_vis();
    int elapsed;
    if (m_inv_left == 0) return 1;
    elapsed = INV - m_inv_left;
    return ((elapsed / FLASH) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_update(input int r, g, ng, w, ox, oy, px, py);
    int col;
    col = ((ox != 0 || oy != 0) && w != 0 &&
           ox >= px && ox <= px + PW - 1 && oy >= py && oy <= py + PH - 1) ? 1 : 0;
    m_hit = 0;
    if (r != 0) begin
      m_health = MAXH; m_dead = 0; m_playing = 0; m_inv_left = 0;
    end else if (ng != 0) begin
      m_health = MAXH; m_dead = 0; m_inv_left = 0; m_playing = g;
    end else if (m_dead != 0) begin
      m_health = 0;
    end else if (m_playing == 0) begin
      if (g != 0) m_playing = 1;
    end else if (m_inv_left > 0) begin
      if (g == 0) begin m_playing = 0; m_inv_left = 0; end
      else m_inv_left = m_inv_left - 1;
    end else begin
      if (g == 0) m_playing = 0;
      else if (col != 0) begin
        m_hit = 1;
        m_health = m_health - 1;
        if (m_health == 0) m_dead = 1;
        else m_inv_left = INV;
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, advance the model, settle.
  task automatic step(input int r, g, ng, w, ox, oy, px, py);
    rst = (r != 0); game_on = (g != 0); new_game = (ng != 0);
    obstacle_working = (w != 0);
    obstacle_x = 12'(ox); obstacle_y = 12'(oy);
    player_x = 12'(px); player_y = 12'(py);
    @(posedge pclk);
    model_update(r, g, ng, w, ox, oy, px, py);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_hit, e_h, e_inv, e_vis, e_go);
    chk({tag, " hit"}, int'(hit), e_hit);
    chk({tag, " health"}, int'(health), e_h);
    chk({tag, " invulnerable"}, int'(invulnerable), e_inv);
    chk({tag, " player_visible"}, int'(player_visible), e_vis);
    chk({tag, " game_over"}, int'(game_over), e_go);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_hit, m_health, (m_inv_left > 0) ? 1 : 0, m_vis(), m_dead);
  endtask

  typedef struct {
    int pre;
    int r, g, ng, w, ox, oy;
    int e_hit, e_health, e_inv, e_vis, e_go;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int px, py, ox, oy, g, r, ng, w, e_vis;

    // pre, rst, game_on, new_game, working, ox, oy -> hit, health, inv, vis, over
    tbl[0]  = '{0, 0, 1, 0, 1, 519, 519, 1, 1, 1, 1, 0};
    tbl[1]  = '{20, 0, 1, 0, 1, 520, 500, 0, 1, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 500, 499, 0, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 510, 510, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 499, 500, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 1, 0, 1, 500, 500, 1, 0, 0, 1, 1};
    tbl[7]  = '{0, 0, 1, 0, 1, 510, 510, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 510, 510, 0, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 1, 1, 1, 510, 510, 0, 3, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 0, 1, 510, 510, 1, 2, 1, 1, 0};
    tbl[11] = '{2, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 510, 510, 0, 2, 0, 1, 0};
    tbl[13] = '{0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0};
    tbl[14] = '{0, 0, 1, 0, 1, 500, 519, 1, 1, 1, 1, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0};

    rst = 1'b0; game_on = 1'b0; new_game = 1'b0; obstacle_working = 1'b0;
    obstacle_x = '0; obstacle_y = '0; player_x = '0; player_y = '0;

    // Reset state, arm, single-cycle hit, then the blink pattern.
    step(1, 0, 0, 0, 0, 0, 500, 500);
    chk_all("reset", 0, 3, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 500, 500);
    chk_all("armed", 0, 3, 0, 1, 0);
    step(0, 1, 0, 1, 505, 510, 500, 500);
    chk_all("first_hit", 1, 2, 1, 1, 0);
    for (int k = 1; k <= INV; k++) begin
      e_vis = (k == INV) ? 1 : (((k / FLASH) % 2 == 0) ? 1 : 0);
      step(0, 1, 0, 0, 0, 0, 500, 500);
      chk_all($sformatf("blink k=%0d", k), 0, 2, (k < INV) ? 1 : 0, e_vis, 0);
    end

    // Table: edges, gating, death, new_game priority, reset mid-window.
    for (int i = 0; i < 16; i++) begin
      repeat (tbl[i].pre) step(0, 1, 0, 0, 0, 0, 500, 500);
      step(tbl[i].r, tbl[i].g, tbl[i].ng, tbl[i].w, tbl[i].ox, tbl[i].oy, 500, 500);
      chk_all($sformatf("vec%0d", i), tbl[i].e_hit, tbl[i].e_health,
              tbl[i].e_inv, tbl[i].e_vis, tbl[i].e_go);
      $display("vec %0d: hit=%0d health=%0d inv=%0d vis=%0d over=%0d", i,
               hit, health, invulnerable, player_visible, game_over);
    end

    // Sustained overlap from full health: one hit per 21 cycles until dead.
    step(1, 0, 0, 0, 0, 0, 500, 500);
    step(0, 1, 0, 0, 0, 0, 500, 500);
    for (int c = 0; c < 60; c++) begin
      int nh;
      nh = (c >= 42) ? 3 : (c >= 21) ? 2 : 1;
      step(0, 1, 0, 1, 510, 510, 500, 500);
      chk($sformatf("sustain c=%0d hit", c), int'(hit),
          (c == 0 || c == 21 || c == 42) ? 1 : 0);
      chk($sformatf("sustain c=%0d health", c), int'(health), 3 - nh);
      chk($sformatf("sustain c=%0d over", c), int'(game_over), (c >= 42) ? 1 : 0);
      chk($sformatf("sustain c=%0d inv", c), int'(invulnerable),
          (c < 42 && (c % 21) < 20) ? 1 : 0);
    end

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0, 0, 500, 500);
    chk_model("rand_reset");
    g = 1; px = 500; py = 500;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        px = ($urandom_range(0, 3) == 0) ? 4080 + $urandom_range(0, 15) : $urandom_range(100, 3000);
        py = ($urandom_range(0, 3) == 0) ? 4080 + $urandom_range(0, 15) : $urandom_range(100, 3000);
      end
      if ($urandom_range(0, 79) == 0) g = 1 - g;
      r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
      ng = ($urandom_range(0, 59) == 0) ? 1 : 0;
      w  = ($urandom_range(0, 9) == 0) ? 0 : 1;
      if ($urandom_range(0, 3) == 0) begin
        ox = 0; oy = 0;
      end else begin
        ox = px - 2 + $urandom_range(0, 24);
        oy = py - 2 + $urandom_range(0, 24);
        if (ox > 4095) ox = 4095;
        if (oy > 4095) oy = 4095;
      end
      step(r, g, ng, w, ox, oy, px, py);
      chk_model($sformatf("rand n=%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_collision_tracker.md
Name: player_collision_tracker

Overview:
- Sits directly downstream of the laser obstacle generators.
- Consumes their per-pixel obstacle coordinate outputs and the player's box position, and detects overlap between a drawn obstacle pixel and the player.
- Manages player health, with an invulnerability window after each hit.
- Produces hit, health, game-over and player-blink signals for the game control and player drawing stages.

Parameters:
- PLAYER_W, 20, player box width in pixels.
- PLAYER_H, 20, player box height in pixels.
- MAX_HEALTH, 3, health loaded at reset and on new_game (1..7).
- INVULN_CYCLES, 65000000, length of the invulnerability window in pclk cycles.
- FLASH_CYCLES, 3250000, blink half-period during invulnerability, in pclk cycles.
- CNT_W, 26, width of the invulnerability and blink counters.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- game_on  in  1  gameplay active
- new_game  in  1  one-cycle pulse: reload health, leave DEAD
- obstacle_working  in  1  OR of obstacle working flags
- obstacle_x  in  12  obstacle pixel x; 0 when no obstacle pixel
- obstacle_y  in  12  obstacle pixel y; 0 when no obstacle pixel
- player_x  in  12  player box left edge
- player_y  in  12  player box top edge
- hit  out  1  one-cycle pulse per accepted hit
- health  out  3  remaining health
- invulnerable  out  1  high during the invulnerability window
- player_visible  out  1  player draw enable (blinks while invulnerable)
- game_over  out  1  high while in DEAD

Behaviour:
- Reset: rst is synchronous, active-high; clock is pclk. On reset:
  - state=IDLE, health=MAX_HEALTH
  - hit=0, invulnerable=0, game_over=0, player_visible=1
  - both counters=0
- Obstacle pixel valid when (obstacle_x!=0 || obstacle_y!=0) && obstacle_working.
- Overlap test, inclusive on all edges:
  - player_x <= obstacle_x <= player_x+PLAYER_W-1
  - player_y <= obstacle_y <= player_y+PLAYER_H-1
  - Sums are computed at 13 bits, so no wrap-around at 4095.
- Collision: collide = valid && overlap, evaluated combinationally on the current inputs.
- All outputs are registered. Latency is 1 cycle: an input collision in cycle N gives hit=1 and the updated health in cycle N+1.
- State machine:
  - IDLE: invulnerable=0, player_visible=1, counters cleared. game_on=1 goes to ARMED.
  - ARMED: on collide, pulse hit=1 and set health=health-1.
    - New health 0: go to DEAD, game_over=1.
    - Otherwise: go to INVULN, invulnerable=1, counters cleared.
    - game_on=0 goes to IDLE.
  - INVULN: collide is ignored (no hit, no decrement).
    - Invulnerability counter increments each cycle.
    - When it reaches INVULN_CYCLES-1: go to ARMED, invulnerable=0, player_visible=1.
    - Blink counter wraps at FLASH_CYCLES-1 and toggles player_visible on wrap. The first toggle (to 0) comes FLASH_CYCLES cycles after entry.
    - game_on=0 goes to IDLE. Health is kept; invulnerability is abandoned.
  - DEAD: game_over=1, player_visible=1, health=0. collide and game_on are ignored. Only new_game exits.
- new_game, in any state:
  - Sets health=MAX_HEALTH, game_over=0, invulnerable=0, counters cleared.
  - Next state is ARMED if game_on=1, else IDLE.
  - new_game has priority over a simultaneous collide: no hit and no decrement that cycle.
- hit is never high for two consecutive cycles. A multi-pixel overlap produces exactly one hit, because INVULN is entered immediately.
- health never underflows: a decrement only occurs in ARMED with health>=1.
- rst asserted mid-operation in any state forces the full reset values on the next edge.

Test Plan:
Bench parameters: PLAYER_W=PLAYER_H=20, MAX_HEALTH=3, INVULN_CYCLES=20, FLASH_CYCLES=4.
1. Hit and invulnerability: reset, game_on=1, player at (500,500), obstacle_working=1, obstacle (505,510) for 1 cycle -> next cycle hit=1, health=2, invulnerable=1. player_visible falls to 0 4 cycles after INVULN entry and toggles every 4 cycles. invulnerable=0 and player_visible=1 after 20 cycles.
2. Edge inclusivity: with invulnerability expired, obstacle (519,519) -> hit, health=1. After invulnerability expires, (520,500) -> no hit. (500,499) -> no hit. (0,0) with working=1 -> no hit.
3. Sustained overlap and death: hold obstacle (510,510) continuously from health=3 -> exactly one hit per 21-cycle interval. The third hit gives health=0 and game_over=1. Further overlap gives no hit, health stays 0.
4. New game priority: in DEAD, new_game=1 together with colliding obstacle -> hit=0, health=3, game_over=0, state ARMED. The next colliding cycle gives hit=1, health=2.
5. Gating: obstacle_working=0 with overlapping coords -> no hit. game_on=0 during INVULN -> invulnerable=0, health kept. game_on=1 again -> ARMED with immediate hit sensitivity.
6. Reset mid-INVULN: rst=1 for one cycle -> health=3, invulnerable=0, hit=0, game_over=0, player_visible=1.
